run_length_detector: RTL and testbench
======================================

RUN_LENGTH_DETECTOR -- requirements
Module: run_length_detector

Interface
REQ-001 The block SHALL have the parameter THRESH_X, default 2, giving the run length (1..THRESH_Y) at which doutx asserts.
REQ-002 The block SHALL have the parameter THRESH_Y, default 3, giving the run length (THRESH_X..2^CNT_W-1) at which douty asserts.
REQ-003 The block SHALL have the parameter CNT_W, default 4, giving the run-length counter width.
REQ-004 The block SHALL have the parameter EVT_W, default 8, giving the event counter width.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have the port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have the port din, input, 1 bit: serial data bit.
REQ-008 The block SHALL have the port cen, input, 1 bit: bit qualifier; din is consumed only when cen=1.
REQ-009 The block SHALL have the port pol_en, input, 1 bit: 0 counts runs of ones only, 1 counts runs of ones or zeros.
REQ-010 The block SHALL have the port clr_cnt, input, 1 bit: synchronous clear of evt_cnt.
REQ-011 The block SHALL have the port doutx, output, 1 bit: Mealy flag, current run >= THRESH_X.
REQ-012 The block SHALL have the port douty, output, 1 bit: Mealy flag, current run >= THRESH_Y.
REQ-013 The block SHALL have the port run_len, output, CNT_W bits: registered length of the current qualifying run.
REQ-014 The block SHALL have the port run_val, output, 1 bit: registered bit value of the current run.
REQ-015 The block SHALL have the port evt_cnt, output, EVT_W bits: registered count of THRESH_Y events.

Function
REQ-016 The block SHALL define a bit as qualifying when cen=1 and either din=1 or pol_en=1.
REQ-017 The block SHALL compute run_next combinationally: 0 if the bit is not qualifying; run_len+1, saturated at 2^CNT_W-1, if run_len>0 and din==run_val; otherwise 1.
REQ-018 The block SHALL, when cen=1 and resetn=1, load run_len<=run_next and run_val<=din on each rising clk edge.
REQ-019 The block SHALL, when cen=0, hold run_len, run_val and evt_cnt, and drive doutx=douty=0.
REQ-020 The block SHALL drive doutx = cen & (run_next >= THRESH_X) combinationally, in the same cycle as the completing bit with zero latency.
REQ-021 The block SHALL drive douty = cen & (run_next >= THRESH_Y) combinationally.
REQ-022 The block SHALL keep doutx and douty asserted on every further qualifying bit of the same run, including while run_len is saturated.
REQ-023 The block SHALL increment evt_cnt by 1 when cen=1 and run_next == THRESH_Y, giving one event per run, and saturate evt_cnt at 2^EVT_W-1.
REQ-024 The block SHALL let clr_cnt=1 clear evt_cnt to 0 on the next edge, with priority over a simultaneous increment; clr_cnt SHALL NOT affect run_len.
REQ-025 The block SHALL, when a polarity change occurs with pol_en=1, start a new run of length 1 with the new value, so runs of ones and zeros are never merged.
REQ-026 The block SHALL allow pol_en to change mid-run, taking effect on the current bit; a zero arriving with pol_en=0 resets run_len to 0.
REQ-027 The block SHALL treat the parameter constraint 1 <= THRESH_X <= THRESH_Y <= 2^CNT_W-1 as an elaboration-time error if it is violated.

Reset
REQ-028 The block SHALL, when resetn=0 at a rising clk edge, set run_len=0, run_val=0 and evt_cnt=0, overriding cen and clr_cnt.
REQ-029 The block SHALL force doutx=douty=0 combinationally while resetn=0.
REQ-030 The block SHALL, on a reset asserted mid-run, discard the run; the first qualifying bit after reset starts at run_len=1.

Verification
REQ-031 The bench SHALL check defaults with pol_en=0, cen=1, din=0,1,1,1,1,0: doutx=0,0,1,1,1,0; douty=0,0,0,1,1,0; evt_cnt ends at 1.
REQ-032 The bench SHALL check pol_en=1, din=0,0,0,1,1: douty=1 on the third 0, run_val=1 and run_len=1 after the first 1, doutx=1 on the second 1, evt_cnt=1.
REQ-033 The bench SHALL check cen gaps with din=1,(cen=0),1,(cen=0),1: flags are 0 in gap cycles, run_len is held, douty=1 on the third qualified 1.
REQ-034 The bench SHALL check saturation with 20 consecutive ones: run_len sticks at 15, doutx and douty stay 1, and evt_cnt increments only once.
REQ-035 The bench SHALL check that clr_cnt=1 in the same cycle as a THRESH_Y event leaves evt_cnt=0; and that evt_cnt=255 plus a further event remains at 255.
REQ-036 The bench SHALL check resetn=0 for one cycle mid-run after two ones: doutx=0 during reset, run_len=0 and evt_cnt=0 after the edge, and the next 1 gives run_len=1 with doutx=0.

Source files
------------

// File: rtl/run_length_detector.sv
// Serial run-length detector: tracks the current run of equal bits, raises
// zero-latency threshold flags and counts runs that reach THRESH_Y.
module run_length_detector #(
  parameter int THRESH_X = 2,
  parameter int THRESH_Y = 3,
  parameter int CNT_W    = 4,
  parameter int EVT_W    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din,
  input  logic             cen,
  input  logic             pol_en,
  input  logic             clr_cnt,
  output logic             doutx,
  output logic             douty,
  output logic [CNT_W-1:0] run_len,
  output logic             run_val,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
  localparam logic [CNT_W-1:0] TX      = CNT_W'(THRESH_X);
  localparam logic [CNT_W-1:0] TY      = CNT_W'(THRESH_Y);

  if ((THRESH_X < 1) || (THRESH_X > THRESH_Y) || (THRESH_Y >= (1 << CNT_W))) begin : gBadParams
    $error("run_length_detector: need 1 <= THRESH_X <= THRESH_Y <= 2**CNT_W-1");
  end

  logic [CNT_W-1:0] runLen_q, runLen_d, runNext;
  logic             runVal_q, runVal_d;
  logic [EVT_W-1:0] evtCnt_q, evtCnt_d;
  logic             qualify, sameRun, evtHit;

  // A saturated run keeps runNext pinned at RUN_MAX, so the event must exclude
  // that continuation or THRESH_Y == RUN_MAX would count every further bit.
  always_comb begin
    qualify  = cen & (din | pol_en);
    sameRun  = (runLen_q != '0) && (din == runVal_q);
    runNext  = '0;
    runLen_d = runLen_q;
    runVal_d = runVal_q;
    evtCnt_d = evtCnt_q;

    if (qualify) begin
      if (sameRun) begin
        runNext = (runLen_q == RUN_MAX) ? RUN_MAX : runLen_q + CNT_W'(1);
      end else begin
        runNext = CNT_W'(1);
      end
    end

    evtHit = qualify && (runNext == TY) && !(sameRun && (runLen_q == RUN_MAX));

    if (cen) begin
      runLen_d = runNext;
      runVal_d = din;
    end

    if (clr_cnt) begin
      evtCnt_d = '0;
    end else if (evtHit && (evtCnt_q != EVT_MAX)) begin
      evtCnt_d = evtCnt_q + EVT_W'(1);
    end

    doutx = resetn & cen & (runNext >= TX);
    douty = resetn & cen & (runNext >= TY);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      runLen_q <= '0;
      runVal_q <= 1'b0;
      evtCnt_q <= '0;
    end else begin
      runLen_q <= runLen_d;
      runVal_q <= runVal_d;
      evtCnt_q <= evtCnt_d;
    end
  end

  assign run_len = runLen_q;
  assign run_val = runVal_q;
  assign evt_cnt = evtCnt_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Scenario bench for run_length_detector: each row's expected flags and
// registered state are queued on drive and popped once the DUT has produced them.
module tb_run_length_detector;

  typedef struct packed {
    logic       x;
    logic       y;
    logic [3:0] len;
    logic       val;
    logic [7:0] evt;
  } exp_t;

  typedef struct packed {
    logic d;
    logic c;
    logic p;
    logic clr;
    logic rn;
    exp_t e;
  } row_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       din = 1'b0;
  logic       cen = 1'b0;
  logic       pol_en = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       doutx, douty, run_val;
  logic [3:0] run_len;
  logic [7:0] evt_cnt;

  logic       obsX, obsY, obsVal;
  logic [3:0] obsLen;
  logic [7:0] obsEvt;
  exp_t       expQ[$];
  int         total = 0;
  int         bad = 0;

  run_length_detector dut (
    .clk(clk), .resetn(resetn), .din(din), .cen(cen), .pol_en(pol_en),
    .clr_cnt(clr_cnt), .doutx(doutx), .douty(douty), .run_len(run_len),
    .run_val(run_val), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input int d, c, p, clr, rn, x, y, len, val, evt);
    row_t r;
    r.d = d[0]; r.c = c[0]; r.p = p[0]; r.clr = clr[0]; r.rn = rn[0];
    r.e.x = x[0]; r.e.y = y[0]; r.e.len = len[3:0]; r.e.val = val[0];
    r.e.evt = evt[7:0];
    return r;
  endfunction

  // Drives one bit period: flags are captured mid-cycle, registers just after the edge.
  task automatic applyStimulus(input row_t r);
    expQ.push_back(r.e);
    din = r.d; cen = r.c; pol_en = r.p; clr_cnt = r.clr; resetn = r.rn;
    @(negedge clk);
    obsX = doutx; obsY = douty;
    @(posedge clk);
    #1;
    obsLen = run_len; obsVal = run_val; obsEvt = evt_cnt;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,1,0,0,0, 0,0,0,0,0), mk(1,1,1,1,0, 0,0,0,0,0)};
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL reset flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL reset regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_basic();
    row_t rows[$];
    exp_t e;
    rows = '{mk(0,0,0,0,0, 0,0,0,0,0),
             mk(0,1,0,0,1, 0,0,0,0,0), mk(1,1,0,0,1, 0,0,1,1,0),
             mk(1,1,0,0,1, 1,0,2,1,0), mk(1,1,0,0,1, 1,1,3,1,1),
             mk(1,1,0,0,1, 1,1,4,1,1), mk(0,1,0,0,1, 0,0,0,0,1)};
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL basic flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL basic regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_polarity();
    row_t rows[$];
    exp_t e;
    rows = '{mk(0,0,0,0,0, 0,0,0,0,0),
             mk(0,1,1,0,1, 0,0,1,0,0), mk(0,1,1,0,1, 1,0,2,0,0),
             mk(0,1,1,0,1, 1,1,3,0,1), mk(1,1,1,0,1, 0,0,1,1,1),
             mk(1,1,1,0,1, 1,0,2,1,1), mk(0,1,0,0,1, 0,0,0,0,1),
             mk(1,1,0,0,1, 0,0,1,1,1)};
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL polarity flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL polarity regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_cen_gap();
    row_t rows[$];
    exp_t e;
    rows = '{mk(0,0,0,0,0, 0,0,0,0,0),
             mk(1,1,0,0,1, 0,0,1,1,0), mk(0,0,0,0,1, 0,0,1,1,0),
             mk(1,1,0,0,1, 1,0,2,1,0), mk(1,0,1,0,1, 0,0,2,1,0),
             mk(1,1,0,0,1, 1,1,3,1,1)};
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL cen_gap flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL cen_gap regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
    for (int k = 1; k <= 20; k++) begin
      rows.push_back(mk(1,1,0,0,1, int'(k >= 2), int'(k >= 3), (k > 15) ? 15 : k, 1, int'(k >= 3)));
    end
    rows.push_back(mk(0,1,0,0,1, 0,0,0,0,1));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL saturation flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL saturation regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_clear();
    row_t rows[$];
    exp_t e;
    rows = '{mk(0,0,0,0,0, 0,0,0,0,0),
             mk(1,1,0,0,1, 0,0,1,1,0), mk(1,1,0,0,1, 1,0,2,1,0),
             mk(1,1,0,1,1, 1,1,3,1,0), mk(1,1,0,0,1, 1,1,4,1,0),
             mk(0,1,0,0,1, 0,0,0,0,0), mk(1,1,0,0,1, 0,0,1,1,0),
             mk(1,1,0,0,1, 1,0,2,1,0), mk(1,1,0,0,1, 1,1,3,1,1),
             mk(1,1,0,1,1, 1,1,4,1,0)};
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL clear flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL clear regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_evt_saturation();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
    for (int k = 1; k <= 256; k++) begin
      rows.push_back(mk(1,1,0,0,1, 0,0,1,1, k - 1));
      rows.push_back(mk(1,1,0,0,1, 1,0,2,1, k - 1));
      rows.push_back(mk(1,1,0,0,1, 1,1,3,1, (k > 255) ? 255 : k));
      rows.push_back(mk(0,1,0,0,1, 0,0,0,0, (k > 255) ? 255 : k));
    end
    rows[rows.size() - 4].e.evt = 8'd255;
    rows[rows.size() - 3].e.evt = 8'd255;
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL evt_sat flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL evt_sat regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    row_t rows[$];
    exp_t e;
    rows = '{mk(0,0,0,0,0, 0,0,0,0,0),
             mk(1,1,0,0,1, 0,0,1,1,0), mk(1,1,0,0,1, 1,0,2,1,0),
             mk(1,1,0,0,1, 1,1,3,1,1), mk(0,1,0,0,1, 0,0,0,0,1),
             mk(1,1,0,0,1, 0,0,1,1,1), mk(1,1,0,0,1, 1,0,2,1,1),
             mk(1,1,0,0,0, 0,0,0,0,0), mk(1,1,0,0,1, 0,0,1,1,0)};
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      e = expQ.pop_front();
      total++;
      if ({obsX, obsY} !== {e.x, e.y}) begin
        bad++; $display("[TB] FAIL reset_midrun flags row %0d: got x=%b y=%b want x=%b y=%b", i, obsX, obsY, e.x, e.y);
      end
      total++;
      if ({obsLen, obsVal, obsEvt} !== {e.len, e.val, e.evt}) begin
        bad++; $display("[TB] FAIL reset_midrun regs row %0d: got len=%0d val=%b evt=%0d want len=%0d val=%b evt=%0d", i, obsLen, obsVal, obsEvt, e.len, e.val, e.evt);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_polarity();
    test_cen_gap();
    test_saturation();
    test_clear();
    test_evt_saturation();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
